// File: rtl/digit_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_ctrl_if
// Brief    : Key-event handshake and shift-register command bus of the
//            calculator entry-line sequencer. The master modport is the
//            controller; the slave modport is its environment.
// Revision : 1.0  initial release
// ============================================================================
interface digit_entry_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             key_ready;
    logic [1:0]       sr_ctrl;
    logic [WIDTH-1:0] sr_shift_in;
    logic             sr_rdy;

    modport master (
        input  key_valid,
        input  key_code,
        input  sr_rdy,
        output key_ready,
        output sr_ctrl,
        output sr_shift_in
    );

    modport slave (
        output key_valid,
        output key_code,
        output sr_rdy,
        input  key_ready,
        input  sr_ctrl,
        input  sr_shift_in
    );
endinterface
`default_nettype wire

// File: rtl/digit_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_ctrl
// Brief    : Translates keypad events into digit-array shift-register
//            commands and tracks the entered digit count.
//            Optional macro LEADING_ZERO_SUPPRESS_EN drops a leading 0 digit.
// Revision : 1.0  initial release
// ============================================================================
module digit_entry_ctrl #(
    parameter int WIDTH   = 4,
    parameter int LENGTH  = 10,
    parameter int TIMEOUT = 16   // must be at least 2
) (
    input  wire logic                          clk,
    input  wire logic                          srst,
    digit_entry_ctrl_if.master                 bus,
    output logic [$clog2(LENGTH+1)-1:0]        digit_count,
    output logic                               full,
    output logic                               empty,
    output logic                               busy,
    output logic                               overflow,
    output logic                               bad_key,
    output logic                               timeout
);

    localparam int c_CNT_W = $clog2(LENGTH + 1);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_CMD_HOLD  = 2'b00;
    localparam logic [1:0] c_CMD_SHIFT = 2'b01;
    localparam logic [1:0] c_CMD_DEL   = 2'b10;
    localparam logic [1:0] c_CMD_CLR   = 2'b11;

    localparam logic [c_CNT_W-1:0] c_LEN      = c_CNT_W'(LENGTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_pending;
    logic [1:0]          w_pending_nxt;
    logic [WIDTH-1:0]    r_shift_in;
    logic [WIDTH-1:0]    w_shift_in_nxt;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [c_TMR_W-1:0]  r_tmr;
    logic [c_TMR_W-1:0]  w_tmr_nxt;
    logic                r_overflow;
    logic                w_overflow_nxt;
    logic                r_bad_key;
    logic                w_bad_key_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic [1:0]          w_sr_ctrl;
    logic                w_busy;

    logic w_key_ready;
    logic w_accept;
    logic w_is_digit;
    logic w_is_bs;
    logic w_is_clr;
    logic w_zero_drop;

    // srst is part of ready so no key is reported as taken during reset
    assign w_key_ready = (r_state == ST_IDLE) && bus.sr_rdy && srst;
    assign w_accept    = bus.key_valid && w_key_ready;
    assign w_is_digit  = (bus.key_code <= 4'd9);
    assign w_is_bs     = (bus.key_code == 4'hA);
    assign w_is_clr    = (bus.key_code == 4'hB);

`ifdef LEADING_ZERO_SUPPRESS_EN
    assign w_zero_drop = (bus.key_code == 4'd0) && (r_count == '0);
`else
    assign w_zero_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!srst) begin
            r_state    <= ST_IDLE;
            r_pending  <= c_CMD_HOLD;
            r_shift_in <= '0;
            r_count    <= '0;
            r_tmr      <= '0;
            r_overflow <= 1'b0;
            r_bad_key  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_shift_in <= w_shift_in_nxt;
            r_count    <= w_count_nxt;
            r_tmr      <= w_tmr_nxt;
            r_overflow <= w_overflow_nxt;
            r_bad_key  <= w_bad_key_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_shift_in_nxt = r_shift_in;
        w_count_nxt    = r_count;
        w_tmr_nxt      = r_tmr;
        w_overflow_nxt = 1'b0;
        w_bad_key_nxt  = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_sr_ctrl      = c_CMD_HOLD;
        w_busy         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        if (w_zero_drop) begin
                            w_state_nxt = ST_IDLE;
                        end else if (r_count < c_LEN) begin
                            w_shift_in_nxt = WIDTH'(bus.key_code);
                            w_pending_nxt  = c_CMD_SHIFT;
                            w_state_nxt    = ST_ISSUE;
                        end else begin
                            w_overflow_nxt = 1'b1;
                        end
                    end else if (w_is_bs) begin
                        if (r_count != '0) begin
                            w_pending_nxt = c_CMD_DEL;
                            w_state_nxt   = ST_ISSUE;
                        end
                    end else if (w_is_clr) begin
                        // Issued even when empty to force the array to a known state
                        w_pending_nxt = c_CMD_CLR;
                        w_state_nxt   = ST_ISSUE;
                    end else begin
                        w_bad_key_nxt = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                w_sr_ctrl   = r_pending;
                w_busy      = 1'b1;
                w_tmr_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                w_busy = 1'b1;
                // First WAIT cycle (r_tmr==0) lets the shift register drop rdy
                if ((r_tmr != '0) && bus.sr_rdy) begin
                    case (r_pending)
                        c_CMD_SHIFT: if (r_count < c_LEN) w_count_nxt = r_count + c_CNT_ONE;
                        c_CMD_DEL:   if (r_count != '0)  w_count_nxt = r_count - c_CNT_ONE;
                        c_CMD_CLR:   w_count_nxt = '0;
                        default:     w_count_nxt = r_count;
                    endcase
                    w_state_nxt = ST_IDLE;
                end else if (r_tmr == c_TMR_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.key_ready   = w_key_ready;
    assign bus.sr_ctrl     = w_sr_ctrl;
    assign bus.sr_shift_in = r_shift_in;

    assign digit_count = r_count;
    assign full        = (r_count == c_LEN);
    assign empty       = (r_count == '0);
    assign busy        = w_busy;
    assign overflow    = r_overflow;
    assign bad_key     = r_bad_key;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire
